restoring_divider: RTL and testbench
====================================

RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand, quotient and remainder width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, request to begin a division.
REQ-005 The block SHALL have port dividend, input, WIDTH, numerator sampled on an accepted start.
REQ-006 The block SHALL have port divisor, input, WIDTH, denominator sampled on an accepted start.
REQ-007 The block SHALL have port busy, output, 1, high while a division is in progress.
REQ-008 The block SHALL have port done, output, 1, a one-cycle pulse marking a valid result.
REQ-009 The block SHALL have port quotient, output, WIDTH, the result quotient.
REQ-010 The block SHALL have port remainder, output, WIDTH, the result remainder.
REQ-011 The block SHALL have port div_by_zero, output, 1, flags that the last result came from a zero divisor.

Function
REQ-012 The FSM SHALL have three states, IDLE, RUN and DONE; it SHALL use no other states.
REQ-013 In IDLE, start=1 SHALL be accepted at a rising edge: operands are captured, busy is set, and the FSM goes to RUN with a bit counter of WIDTH.
REQ-014 start SHALL be ignored while busy=1; a held start SHALL NOT restart a running division.
REQ-015 Each RUN cycle SHALL perform one restoring step: shift the partial remainder left by one, bringing in the next dividend MSB, then do a trial subtract of the divisor in WIDTH+1 bits.
REQ-016 In that step, a non-negative trial result SHALL be kept and the quotient bit set to 1; a negative trial result SHALL restore the partial remainder and set the quotient bit to 0.
REQ-017 After WIDTH RUN cycles the FSM SHALL enter DONE; done SHALL be 1 for exactly that one cycle, busy SHALL clear, and the FSM SHALL return to IDLE next.
REQ-018 Latency SHALL be fixed: start accepted at edge k gives done=1 in the cycle after edge k+WIDTH+1.
REQ-019 A start seen in the DONE cycle SHALL be ignored; start is accepted only in IDLE.
REQ-020 quotient, remainder and div_by_zero SHALL hold their values from the DONE cycle until the next accepted start completes.
REQ-021 quotient, remainder and div_by_zero SHALL NOT change during RUN; results are staged internally.
REQ-022 When divisor==0 at capture, the FSM SHALL go straight to DONE on the next edge, with quotient all-ones, remainder = dividend and div_by_zero=1.
REQ-023 div_by_zero SHALL be 0 for any nonzero divisor.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH on the outputs, with no saturation.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0 and counter=0, without waiting for a clock edge.
REQ-026 Reset asserted during RUN SHALL abort the division with no done pulse; the first start after reset release SHALL be processed normally.

Configuration
REQ-027 Macro DIVIDER_SIGNED_EN: when defined, dividend, divisor, quotient and remainder SHALL be two's complement.
REQ-028 With DIVIDER_SIGNED_EN defined, operands SHALL be converted to magnitudes, divided unsigned per REQ-015 and REQ-016, and then sign-corrected.
REQ-029 With DIVIDER_SIGNED_EN defined, the quotient SHALL truncate toward zero and the remainder SHALL take the sign of the dividend.
REQ-030 With DIVIDER_SIGNED_EN defined, most-negative/-1 SHALL give quotient = most-negative and remainder 0; zero-divisor handling SHALL still follow REQ-022.
REQ-031 With DIVIDER_SIGNED_EN defined, latency SHALL be unchanged.
REQ-032 When DIVIDER_SIGNED_EN is undefined, all values SHALL be unsigned and no sign logic SHALL be synthesized.

Verification (WIDTH=8)
REQ-033 The bench SHALL cover: unsigned 200/7 -> quotient=28, remainder=4, div_by_zero=0, done 9 edges after the start edge, busy high for the 8 RUN cycles.
REQ-034 The bench SHALL cover: 5/0 -> quotient=0xFF, remainder=5, div_by_zero=1, done one edge after the start edge.
REQ-035 The bench SHALL cover: 255/1 and 3/200 -> (255,0) and (0,3); back-to-back starts issued as soon as done clears give correct independent results.
REQ-036 The bench SHALL cover: start re-pulsed with new operands mid-RUN -> ignored; the result still matches the first operands.
REQ-037 The bench SHALL cover: rst_n pulsed low at RUN cycle 4 -> all outputs 0 immediately and no done pulse; a following 100/10 gives (10,0).
REQ-038 The bench SHALL cover, with DIVIDER_SIGNED_EN defined: -100/7 -> quotient=0xF2 (-14), remainder=0xFE (-2); -128/-1 -> quotient=0x80, remainder=0.

Source files
------------

// File: rtl/restoring_divider.sv
// Multi-cycle restoring divider: one quotient bit per RUN cycle, fixed latency.
// Optional DIVIDER_SIGNED_EN selects two's-complement operands and results.
module restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] part;
    logic [WIDTH-1:0] dvs;
    logic             dz;

    logic [WIDTH-1:0] mag_dvd;
    logic [WIDTH-1:0] mag_dvs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             keep;
    logic [WIDTH-1:0] part_step;
    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;
    logic             finish;

`ifdef DIVIDER_SIGNED_EN
    logic neg_q;
    logic neg_r;

    assign mag_dvd = dividend[WIDTH-1] ? -dividend : dividend;
    assign mag_dvs = divisor[WIDTH-1] ? -divisor : divisor;
`else
    assign mag_dvd = dividend;
    assign mag_dvs = divisor;
`endif

    // acc holds the unconsumed dividend bits and collects quotient bits from the right
    assign shifted   = {part, acc[WIDTH-1]};
    assign trial     = shifted - {1'b0, dvs};
    assign keep      = ~trial[WIDTH];
    assign part_step = keep ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign acc_step  = {acc[WIDTH-2:0], keep};
    assign finish    = dz || (count == '0);

    always_comb begin
        res_q = acc;
        res_r = part;
`ifdef DIVIDER_SIGNED_EN
        if (!dz) begin
            res_q = neg_q ? -acc : acc;
            res_r = neg_r ? -part : part;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (finish) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            acc         <= '0;
            part        <= '0;
            dvs         <= '0;
            dz          <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        count <= CW'(WIDTH);
                        dz    <= (divisor == '0);
                        dvs   <= mag_dvs;
`ifdef DIVIDER_SIGNED_EN
                        neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_r <= dividend[WIDTH-1];
`endif
                        // zero divisor: stage the fixed result right away
                        if (divisor == '0) begin
                            acc  <= '1;
                            part <= dividend;
                        end else begin
                            acc  <= mag_dvd;
                            part <= '0;
                        end
                    end
                end
                RUN: begin
                    if (finish) begin
                        quotient    <= res_q;
                        remainder   <= res_r;
                        div_by_zero <= dz;
                    end else begin
                        acc   <= acc_step;
                        part  <= part_step;
                        count <= count - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider (WIDTH=8): directed cases plus
// random operands checked against plain-arithmetic division.
module tb_restoring_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int total = 0;
    int passed = 0;
    int failed = 0;

    restoring_divider #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic z);
`ifdef DIVIDER_SIGNED_EN
        int sa;
        int sb;
`endif
        if (b == 8'd0) begin
            q = 8'hFF;
            r = a;
            z = 1'b1;
        end else begin
            z = 1'b0;
`ifdef DIVIDER_SIGNED_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
            q  = 8'(sa / sb);
            r  = 8'(sa % sb);
`else
            q = a / b;
            r = a % b;
`endif
        end
    endfunction

    // Called and returning #1 after a rising edge.
    task automatic do_div(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er,
                          input logic ez, input bit repulse);
        logic [7:0] pq;
        logic [7:0] pr;
        logic       pz;
        int         edges;
        int         lat;
        pq  = quotient;
        pr  = remainder;
        pz  = div_by_zero;
        lat = ez ? 1 : 9;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        chk("busy_accept", 32'(busy), 32'd1);
        edges = 0;
        while (!done && edges < 20) begin
            if (repulse) begin
                start    = (edges == 2 || edges == 3);
                dividend = 8'($urandom);
                divisor  = 8'($urandom_range(255, 1));
            end
            @(posedge clk);
            #1;
            edges++;
            if (!done) begin
                chk("busy_run", 32'(busy), 32'd1);
                chk("q_hold_run", 32'(quotient), 32'(pq));
                chk("r_hold_run", 32'(remainder), 32'(pr));
                chk("z_hold_run", 32'(div_by_zero), 32'(pz));
            end
        end
        start = 1'b0;
        chk("latency", 32'(edges), 32'(lat));
        chk("done", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        chk("quotient", 32'(quotient), 32'(eq));
        chk("remainder", 32'(remainder), 32'(er));
        chk("div_by_zero", 32'(div_by_zero), 32'(ez));
        @(posedge clk);
        #1;
        chk("done_pulse", 32'(done), 32'd0);
        chk("q_hold_idle", 32'(quotient), 32'(eq));
        chk("r_hold_idle", 32'(remainder), 32'(er));
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] eq;
        logic [7:0] er;
        logic       ez;
        bit         saw_done;

        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        chk("rst_z", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifdef DIVIDER_SIGNED_EN
        do_div(8'd156, 8'd7, 8'hF2, 8'hFE, 1'b0, 1'b0);
        do_div(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b0);
        do_div(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 1'b0);
        do_div(8'd20, 8'hFD, 8'hFA, 8'd2, 1'b0, 1'b1);
`else
        do_div(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b0);
        do_div(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 1'b0);
        do_div(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b0);
        do_div(8'd3, 8'd200, 8'd0, 8'd3, 1'b0, 1'b0);
        do_div(8'd100, 8'd9, 8'd11, 8'd1, 1'b0, 1'b1);
`endif

        // abort a division mid-RUN with an asynchronous reset
        dividend = 8'd200;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_q", 32'(quotient), 32'd0);
        chk("abort_r", 32'(remainder), 32'd0);
        chk("abort_z", 32'(div_by_zero), 32'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            saw_done = saw_done | done;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            saw_done = saw_done | done;
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);
        do_div(8'd100, 8'd10, 8'd10, 8'd0, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            a = 8'($urandom);
            b = (i % 6 == 5) ? 8'd0 : 8'($urandom);
            model(a, b, eq, er, ez);
            do_div(a, b, eq, er, ez, (i % 4 == 1));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
